// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor.
// FSM encodings, default width and a clog2 helper.
package serial_subtractor_pkg;

  localparam int WIDTH_DEF = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle of the serial subtractor.
// Optional overflow signal: SERIAL_SUB_OVERFLOW_EN.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             overflow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, overflow
  );
  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, overflow
  );
`else
  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );
  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );
`endif
endinterface

// File: rtl/serial_subtractor_cell.sv
// Full-subtractor cell: two half subtractors
// joined by an OR on their borrows.
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);
  assign d  = x ^ y;
  assign bo = ~x & y;
endmodule

module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic d1;
  logic b1;
  logic b2;

  half_subtractor u_hs0 (
    .x (a),
    .y (b),
    .d (d1),
    .bo(b1)
  );

  half_subtractor u_hs1 (
    .x (d1),
    .y (bin),
    .d (d),
    .bo(b2)
  );

  assign bout = b1 | b2;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A-B, LSB first, one bit per clock.
// Optional overflow output: SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  serial_subtractor_if.slave bus
);
  localparam int CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_nx;
  logic [CNT_W-1:0] cnt;
  logic             brw;
  logic             d;
  logic             bo;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             ovf_q;
`endif

  full_subtractor_cell u_cell (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .bin (brw),
    .d   (d),
    .bout(bo)
  );

  assign res_nx = WIDTH'({d, res_sr} >> 1);

  // FSM, operand/result shifters and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      cnt      <= '0;
      brw      <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state  <= ST_SHIFT;
            a_sr   <= bus.a;
            b_sr   <= bus.b;
            res_sr <= '0;
            brw    <= 1'b0;
            cnt    <= '0;
          end
        end
        ST_SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_nx;
          brw    <= bo;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            state    <= ST_DONE;
            diff_q   <= res_nx;
            borrow_q <= bo;
`ifdef SERIAL_SUB_OVERFLOW_EN
            // a_sr[0]/b_sr[0] are the operand MSBs here
            ovf_q    <= (a_sr[0] ^ b_sr[0]) & (d ^ a_sr[0]);
`endif
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy       = (state == ST_SHIFT) || (state == ST_DONE);
  assign bus.done       = (state == ST_DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign bus.overflow   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8).
// Overflow checks enabled with SERIAL_SUB_OVERFLOW_EN.
module tb_serial_subtractor;
  localparam int W = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  serial_subtractor_if #(.WIDTH(W)) intf ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(intf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // start one op; returns cycles-to-done and busy cycle count
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        output int lat, output int nbusy);
    @(negedge clk);
    intf.start = 1'b1;
    intf.a     = ta;
    intf.b     = tb;
    lat   = 0;
    nbusy = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      intf.start = 1'b0;
      if (intf.busy) nbusy++;
      if (intf.done) begin
        lat = n;
        break;
      end
    end
  endtask

  int lat;
  int nb;
  int dcnt;
  logic [W-1:0] ca;
  logic [W-1:0] cb;
  logic [W:0]   model;

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    intf.start = 1'b0;
    intf.a     = '0;
    intf.b     = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(intf.busy), 32'd0);
    chk("rst_done", 32'(intf.done), 32'd0);
    chk("rst_diff", 32'(intf.diff), 32'd0);
    chk("rst_brw", 32'(intf.borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("rst_ovf", 32'(intf.overflow), 32'd0);
`endif
    rst = 1'b0;

    // 10 - 3
    run_op(8'd10, 8'd3, lat, nb);
    chk("t1_lat", 32'(lat), 32'd9);
    chk("t1_busy", 32'(nb), 32'd9);
    chk("t1_diff", 32'(intf.diff), 32'h07);
    chk("t1_brw", 32'(intf.borrow_out), 32'd0);
    @(negedge clk);
    chk("t1_done_off", 32'(intf.done), 32'd0);
    chk("t1_busy_off", 32'(intf.busy), 32'd0);

    // 3 - 10
    run_op(8'd3, 8'd10, lat, nb);
    chk("t2_lat", 32'(lat), 32'd9);
    chk("t2_diff", 32'(intf.diff), 32'hF9);
    chk("t2_brw", 32'(intf.borrow_out), 32'd1);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("t2_ovf", 32'(intf.overflow), 32'd0);
`endif

    // 0x80 - 1
    run_op(8'h80, 8'h01, lat, nb);
    chk("t3_diff", 32'(intf.diff), 32'h7F);
    chk("t3_brw", 32'(intf.borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("t3_ovf", 32'(intf.overflow), 32'd1);
`endif
    run_op(8'h00, 8'h00, lat, nb);
    chk("t3z_diff", 32'(intf.diff), 32'h00);
    chk("t3z_brw", 32'(intf.borrow_out), 32'd0);

    // start mid-SHIFT is ignored
    @(negedge clk);
    intf.start = 1'b1;
    intf.a     = 8'd10;
    intf.b     = 8'd3;
    dcnt = 0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      intf.start = (n == 3);
      intf.a     = (n == 3) ? 8'd1 : 8'd10;
      intf.b     = (n == 3) ? 8'd2 : 8'd3;
      if (intf.done) dcnt++;
    end
    chk("t4_ndone", 32'(dcnt), 32'd1);
    chk("t4_diff", 32'(intf.diff), 32'h07);
    chk("t4_brw", 32'(intf.borrow_out), 32'd0);

    // reset mid-op aborts
    @(negedge clk);
    intf.start = 1'b1;
    intf.a     = 8'd3;
    intf.b     = 8'd10;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      intf.start = 1'b0;
    end
    chk("t5_hold", 32'(intf.diff), 32'h07);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_busy", 32'(intf.busy), 32'd0);
    chk("t5_done", 32'(intf.done), 32'd0);
    chk("t5_diff", 32'(intf.diff), 32'd0);
    chk("t5_brw", 32'(intf.borrow_out), 32'd0);
    dcnt = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (intf.done) dcnt++;
    end
    chk("t5_nodone", 32'(dcnt), 32'd0);
    run_op(8'd200, 8'd55, lat, nb);
    chk("t5_lat", 32'(lat), 32'd9);
    chk("t5_diff2", 32'(intf.diff), 32'd145);

    // rst and start together: rst wins
    @(negedge clk);
    rst        = 1'b1;
    intf.start = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    intf.start = 1'b0;
    chk("t5_rst_start", 32'(intf.busy), 32'd0);

    // start held high, random ops back to back
    ca = 8'($urandom);
    cb = 8'($urandom);
    @(negedge clk);
    intf.start = 1'b1;
    intf.a     = ca;
    intf.b     = cb;
    for (int op = 0; op < 1000; op++) begin
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
        @(negedge clk);
        if (intf.done) begin
          lat = n;
          break;
        end
      end
      chk("t6_period", 32'(lat), (op == 0) ? 32'd9 : 32'd10);
      model = {1'b0, ca} - {1'b0, cb};
      chk("t6_result", 32'({intf.borrow_out, intf.diff}), 32'(model));
      if (lat == 0) break;
      ca     = 8'($urandom);
      cb     = 8'($urandom);
      intf.a = ca;
      intf.b = cb;
    end
    intf.start = 1'b0;
    repeat (12) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
